// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - fetch, memory and cache-fill signal bundle for the refill controller
//
// Ports (master = controller side):
//   fetch:  fetch_valid, fetch_addr, cache_miss, cache_data, flush -> ctrl
//           stall, instr_valid, instr_out                          <- ctrl
//   memory: mem_req, mem_addr <- ctrl ; mem_ack, mem_rdata -> ctrl
//   fill:   fill_wen, fill_idx, fill_tag, fill_data <- ctrl
interface icache_refill_ctrl_if #(
    parameter int ADDR_W      = 16,
    parameter int ISIZE       = 16,
    parameter int NUM_ENTRIES = 4
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              cache_miss;
    logic [ISIZE-1:0]  cache_data;
    logic              flush;
    logic              stall;
    logic              instr_valid;
    logic [ISIZE-1:0]  instr_out;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [ISIZE-1:0]  mem_rdata;
    logic              fill_wen;
    logic [IDX_W-1:0]  fill_idx;
    logic [ADDR_W-1:0] fill_tag;
    logic [ISIZE-1:0]  fill_data;

    modport master (
        input  fetch_valid, fetch_addr, cache_miss, cache_data, flush,
        input  mem_ack, mem_rdata,
        output stall, instr_valid, instr_out,
        output mem_req, mem_addr,
        output fill_wen, fill_idx, fill_tag, fill_data
    );

    modport slave (
        output fetch_valid, fetch_addr, cache_miss, cache_data, flush,
        output mem_ack, mem_rdata,
        input  stall, instr_valid, instr_out,
        input  mem_req, mem_addr,
        input  fill_wen, fill_idx, fill_tag, fill_data
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - instruction cache miss/refill controller with round-robin victim and miss counter
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        icache_refill_ctrl_if.master: fetch handshake, memory req/ack, cache fill strobe
//   miss_count saturating count of completed refills
module icache_refill_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int ISIZE       = 16,
    parameter int NUM_ENTRIES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    icache_refill_ctrl_if.master   bus,
    output logic [CNT_W-1:0]       miss_count
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ISIZE-1:0]  data_q;
    logic [IDX_W-1:0]  victim_q;
    logic [CNT_W-1:0]  count_q;

    logic              miss_start;
    logic              hit;

    logic              stall;
    logic              instr_valid;
    logic [ISIZE-1:0]  instr_out;
    logic              mem_req;
    logic              fill_wen;
    logic [ADDR_W-1:0] fill_tag;
    logic [ISIZE-1:0]  fill_data;

    // A flush cancels the fetch outright, so it suppresses both hit and miss.
    assign miss_start = bus.fetch_valid &  bus.cache_miss & ~bus.flush;
    assign hit        = bus.fetch_valid & ~bus.cache_miss & ~bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            victim_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            // addr_q is only loaded from IDLE, so it stays stable while mem_req is high.
            if (state_q == IDLE && miss_start) begin
                addr_q <= bus.fetch_addr;
            end
            if (state_q == REQ && bus.mem_ack) begin
                data_q <= bus.mem_rdata;
            end
            if (state_q == FILL) begin
                if (victim_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    victim_q <= '0;
                end else begin
                    victim_q <= victim_q + IDX_W'(1);
                end
                if (count_q != {CNT_W{1'b1}}) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d = bus.flush ? IDLE : FILL;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            // The request cannot be withdrawn, so wait out the ack and drop the data.
            DRAIN: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are gated by rst so the combinational fetch paths also read as
    // reset values while reset is held.
    always_comb begin
        stall       = 1'b0;
        instr_valid = 1'b0;
        instr_out   = '0;
        mem_req     = 1'b0;
        fill_wen    = 1'b0;
        fill_tag    = '0;
        fill_data   = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    stall       = miss_start;
                    instr_valid = hit;
                    instr_out   = hit ? bus.cache_data : '0;
                end
                REQ: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                end
                DRAIN: begin
                    mem_req = 1'b1;
                end
                FILL: begin
                    // The entry is written even when the delivery is flushed.
                    fill_wen    = 1'b1;
                    fill_tag    = addr_q;
                    fill_data   = data_q;
                    instr_valid = ~bus.flush;
                    instr_out   = bus.flush ? '0 : data_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign bus.stall       = stall;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_out   = instr_out;
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = addr_q;
    assign bus.fill_wen    = fill_wen;
    assign bus.fill_idx    = victim_q;
    assign bus.fill_tag    = fill_tag;
    assign bus.fill_data   = fill_data;
    assign miss_count      = count_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
    logic clk;
    logic rst;
    logic [15:0] miss_count;
    logic [3:0]  miss_count_small;

    int checks = 0;
    int errors = 0;

    icache_refill_ctrl_if #(.ADDR_W(16), .ISIZE(16), .NUM_ENTRIES(4)) bus ();
    icache_refill_ctrl_if #(.ADDR_W(16), .ISIZE(16), .NUM_ENTRIES(4)) bus_s ();

    icache_refill_ctrl #(.ADDR_W(16), .ISIZE(16), .NUM_ENTRIES(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .miss_count (miss_count)
    );

    // Narrow-counter copy sees the same stimulus so saturation is reachable quickly.
    icache_refill_ctrl #(.ADDR_W(16), .ISIZE(16), .NUM_ENTRIES(4), .CNT_W(4)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_s),
        .miss_count (miss_count_small)
    );

    assign bus_s.fetch_valid = bus.fetch_valid;
    assign bus_s.fetch_addr  = bus.fetch_addr;
    assign bus_s.cache_miss  = bus.cache_miss;
    assign bus_s.cache_data  = bus.cache_data;
    assign bus_s.flush       = bus.flush;
    assign bus_s.mem_ack     = bus.mem_ack;
    assign bus_s.mem_rdata   = bus.mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: a refill is "outstanding" (memory owes data), "wanted"
    // (not yet flushed) and, once data arrives wanted, "delivering" for a cycle.
    logic        m_outstanding;
    logic        m_wanted;
    logic        m_delivering;
    logic [15:0] m_addr;
    logic [15:0] m_data;
    int          m_victim;
    int          m_refills;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_outstanding <= 1'b0;
            m_wanted      <= 1'b0;
            m_delivering  <= 1'b0;
            m_addr        <= 16'h0;
            m_data        <= 16'h0;
            m_victim      <= 0;
            m_refills     <= 0;
        end else if (m_delivering) begin
            m_delivering <= 1'b0;
            m_victim     <= (m_victim + 1) % 4;
            m_refills    <= m_refills + 1;
        end else if (m_outstanding) begin
            if (bus.mem_ack) begin
                m_outstanding <= 1'b0;
                if (m_wanted && !bus.flush) begin
                    m_delivering <= 1'b1;
                    m_data       <= bus.mem_rdata;
                end
            end else if (bus.flush) begin
                m_wanted <= 1'b0;
            end
        end else if (bus.fetch_valid && bus.cache_miss && !bus.flush) begin
            m_outstanding <= 1'b1;
            m_wanted      <= 1'b1;
            m_addr        <= bus.fetch_addr;
        end
    end

    always @(negedge clk) begin
        logic        e_stall, e_iv, e_req, e_wen;
        logic [15:0] e_iout, e_tag, e_data, e_maddr;
        int          e_idx, e_cnt, e_cnt_s;
        if (!rst) begin
            e_stall = 0; e_iv = 0; e_req = 0; e_wen = 0;
            e_iout = 0; e_tag = 0; e_data = 0; e_maddr = 0;
            e_idx = 0; e_cnt = 0; e_cnt_s = 0;
        end else begin
            e_req   = m_outstanding;
            e_wen   = m_delivering;
            e_stall = m_outstanding ? m_wanted
                    : (!m_delivering && bus.fetch_valid && bus.cache_miss && !bus.flush);
            e_iv    = m_delivering ? !bus.flush
                    : (!m_outstanding && bus.fetch_valid && !bus.cache_miss && !bus.flush);
            e_iout  = !e_iv ? 16'h0 : (m_delivering ? m_data : bus.cache_data);
            e_tag   = m_delivering ? m_addr : 16'h0;
            e_data  = m_delivering ? m_data : 16'h0;
            e_maddr = m_addr;
            e_idx   = m_victim;
            e_cnt   = (m_refills > 65535) ? 65535 : m_refills;
            e_cnt_s = (m_refills > 15) ? 15 : m_refills;
        end
        chk("m_stall",       32'(bus.stall),        32'(e_stall));
        chk("m_instr_valid", 32'(bus.instr_valid),  32'(e_iv));
        chk("m_instr_out",   32'(bus.instr_out),    32'(e_iout));
        chk("m_mem_req",     32'(bus.mem_req),      32'(e_req));
        chk("m_mem_addr",    32'(bus.mem_addr),     32'(e_maddr));
        chk("m_fill_wen",    32'(bus.fill_wen),     32'(e_wen));
        chk("m_fill_idx",    32'(bus.fill_idx),     32'(e_idx));
        chk("m_fill_tag",    32'(bus.fill_tag),     32'(e_tag));
        chk("m_fill_data",   32'(bus.fill_data),    32'(e_data));
        chk("m_miss_count",  32'(miss_count),       32'(e_cnt));
        chk("m_miss_count_s",32'(miss_count_small), 32'(e_cnt_s));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 16'h0;
        bus.cache_miss  = 1'b0;
        bus.cache_data  = 16'h0;
        bus.flush       = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 16'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Miss on a, memory acks after lat REQ cycles; samples the FILL cycle outputs.
    task automatic refill(input logic [15:0] a, input int lat, input logic [15:0] d,
                          input logic fl_fill, output logic [1:0] idx, output logic [15:0] tag,
                          output logic [15:0] data, output logic wen, output logic iv,
                          output logic [15:0] iout);
        bus.fetch_valid = 1'b1;
        bus.cache_miss  = 1'b1;
        bus.fetch_addr  = a;
        tick();
        repeat (lat) tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        tick();
        bus.mem_ack     = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.cache_miss  = 1'b0;
        bus.flush       = fl_fill;
        #3;
        idx  = bus.fill_idx;
        tag  = bus.fill_tag;
        data = bus.fill_data;
        wen  = bus.fill_wen;
        iv   = bus.instr_valid;
        iout = bus.instr_out;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        logic [1:0]  idx;
        logic [15:0] tag, data, iout;
        logic        wen, iv;
        logic [1:0]  rr_exp [5];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        #3;
        chk("reset_mem_req",    32'(bus.mem_req),  32'h0);
        chk("reset_miss_count", 32'(miss_count),   32'h0);
        chk("reset_fill_idx",   32'(bus.fill_idx), 32'h0);
        tick();
        rst = 1'b1;

        // Hit: zero-latency delivery.
        bus.fetch_valid = 1'b1;
        bus.cache_miss  = 1'b0;
        bus.cache_data  = 16'h1234;
        #3;
        chk("hit_instr_valid", 32'(bus.instr_valid), 32'h1);
        chk("hit_instr_out",   32'(bus.instr_out),   32'h1234);
        chk("hit_stall",       32'(bus.stall),       32'h0);
        chk("hit_mem_req",     32'(bus.mem_req),     32'h0);
        tick();

        // Flush in IDLE suppresses a miss.
        bus.cache_miss = 1'b1;
        bus.flush      = 1'b1;
        #3;
        chk("idle_flush_stall", 32'(bus.stall),       32'h0);
        chk("idle_flush_iv",    32'(bus.instr_valid), 32'h0);
        tick();
        bus.flush = 1'b0;
        bus.cache_miss = 1'b0;
        bus.fetch_valid = 1'b0;
        #3;
        chk("idle_flush_no_req", 32'(bus.mem_req), 32'h0);
        tick();

        // Miss with memory acking 3 cycles after mem_req rises.
        refill(16'h0040, 3, 16'hBEEF, 1'b0, idx, tag, data, wen, iv, iout);
        chk("miss3_fill_wen",  32'(wen),  32'h1);
        chk("miss3_fill_idx",  32'(idx),  32'h0);
        chk("miss3_fill_tag",  32'(tag),  32'h0040);
        chk("miss3_fill_data", 32'(data), 32'hBEEF);
        chk("miss3_iv",        32'(iv),   32'h1);
        chk("miss3_instr_out", 32'(iout), 32'hBEEF);
        #3;
        chk("miss3_count", 32'(miss_count), 32'h1);
        tick();

        // Round-robin wrap from a fresh reset.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            refill(16'h0100 + 16'(i), 0, 16'hA000 + 16'(i), 1'b0, idx, tag, data, wen, iv, iout);
            chk("rr_fill_idx", 32'(idx), 32'(rr_exp[i]));
        end
        #3;
        chk("rr_count", 32'(miss_count), 32'h5);
        tick();

        // Flush one cycle into REQ, ack two cycles later.
        bus.fetch_valid = 1'b1;
        bus.cache_miss  = 1'b1;
        bus.fetch_addr  = 16'h0200;
        tick();
        tick();
        bus.flush = 1'b1;
        #3;
        chk("fr_req_stall", 32'(bus.stall), 32'h1);
        tick();
        bus.flush      = 1'b0;
        bus.fetch_addr = 16'h0999;
        #3;
        chk("fr_drain_req",   32'(bus.mem_req),  32'h1);
        chk("fr_drain_stall", 32'(bus.stall),    32'h0);
        chk("fr_drain_addr",  32'(bus.mem_addr), 32'h0200);
        tick();
        bus.mem_ack     = 1'b1;
        bus.mem_rdata   = 16'h5555;
        bus.fetch_valid = 1'b0;
        bus.cache_miss  = 1'b0;
        #3;
        chk("fr_ack_req", 32'(bus.mem_req),  32'h1);
        chk("fr_ack_wen", 32'(bus.fill_wen), 32'h0);
        tick();
        bus.mem_ack = 1'b0;
        #3;
        chk("fr_after_wen",   32'(bus.fill_wen),    32'h0);
        chk("fr_after_iv",    32'(bus.instr_valid), 32'h0);
        chk("fr_after_req",   32'(bus.mem_req),     32'h0);
        chk("fr_after_idx",   32'(bus.fill_idx),    32'h1);
        chk("fr_after_count", 32'(miss_count),      32'h5);
        tick();

        // Flush arriving together with the ack returns to IDLE without a fill.
        bus.fetch_valid = 1'b1;
        bus.cache_miss  = 1'b1;
        bus.fetch_addr  = 16'h0300;
        tick();
        bus.flush     = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        idle_inputs();
        #3;
        chk("fa_wen",   32'(bus.fill_wen), 32'h0);
        chk("fa_req",   32'(bus.mem_req),  32'h0);
        chk("fa_count", 32'(miss_count),   32'h5);
        tick();

        // Flush during FILL: entry still written, delivery dropped.
        refill(16'h0123, 1, 16'hCAFE, 1'b1, idx, tag, data, wen, iv, iout);
        chk("ff_fill_wen",  32'(wen),  32'h1);
        chk("ff_fill_idx",  32'(idx),  32'h1);
        chk("ff_fill_tag",  32'(tag),  32'h0123);
        chk("ff_fill_data", 32'(data), 32'hCAFE);
        chk("ff_iv",        32'(iv),   32'h0);
        chk("ff_instr_out", 32'(iout), 32'h0);
        #3;
        chk("ff_count", 32'(miss_count),   32'h6);
        chk("ff_victim", 32'(bus.fill_idx), 32'h2);
        tick();

        // Asynchronous reset in the middle of REQ.
        bus.fetch_valid = 1'b1;
        bus.cache_miss  = 1'b1;
        bus.fetch_addr  = 16'h0400;
        tick();
        #1;
        chk("ar_req_before", 32'(bus.mem_req), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_mem_req",  32'(bus.mem_req),  32'h0);
        chk("ar_stall",    32'(bus.stall),    32'h0);
        chk("ar_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("ar_fill_idx", 32'(bus.fill_idx), 32'h0);
        chk("ar_count",    32'(miss_count),   32'h0);
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;

        // Saturation: the 4-bit copy must stick at 15 while the 16-bit counter keeps going.
        for (int i = 0; i < 20; i++) begin
            refill(16'h1000 + 16'(i), 0, 16'h7000 + 16'(i), 1'b0, idx, tag, data, wen, iv, iout);
        end
        #3;
        chk("sat_count",       32'(miss_count),       32'd20);
        chk("sat_count_small", 32'(miss_count_small), 32'd15);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
